// File: rtl/div_issue_queue_if.sv
// Dispatch, CDB snoop, flush and issue signals shared by div_issue_queue and its neighbours.
interface div_issue_queue_if;
  logic       Dis_DivWrite;
  logic [4:0] Dis_RobTag;
  logic [5:0] Dis_RdPhyAddr;
  logic       Dis_RdWrite;
  logic [5:0] Dis_RsPhyAddr;
  logic       Dis_RsReady;
  logic [5:0] Dis_RtPhyAddr;
  logic       Dis_RtReady;
  logic       Cdb_Valid;
  logic       Cdb_RdWrite;
  logic [5:0] Cdb_RdPhyAddr;
  logic       Cdb_Flush;
  logic [4:0] Rob_TopPtr;
  logic [4:0] Cdb_RobDepth;
  logic       Div_ExeRdy;
  logic       DivQ_Full;
  logic       Iss_Div;
  logic [4:0] Iss_RobTag;
  logic [5:0] Iss_RdPhyAddr;
  logic       Iss_RdWrite;
  logic [5:0] Iss_RsPhyAddr;
  logic [5:0] Iss_RtPhyAddr;

  modport master (
    output Dis_DivWrite, Dis_RobTag, Dis_RdPhyAddr, Dis_RdWrite,
           Dis_RsPhyAddr, Dis_RsReady, Dis_RtPhyAddr, Dis_RtReady,
           Cdb_Valid, Cdb_RdWrite, Cdb_RdPhyAddr, Cdb_Flush,
           Rob_TopPtr, Cdb_RobDepth, Div_ExeRdy,
    input  DivQ_Full, Iss_Div, Iss_RobTag, Iss_RdPhyAddr, Iss_RdWrite,
           Iss_RsPhyAddr, Iss_RtPhyAddr
  );

  modport slave (
    input  Dis_DivWrite, Dis_RobTag, Dis_RdPhyAddr, Dis_RdWrite,
           Dis_RsPhyAddr, Dis_RsReady, Dis_RtPhyAddr, Dis_RtReady,
           Cdb_Valid, Cdb_RdWrite, Cdb_RdPhyAddr, Cdb_Flush,
           Rob_TopPtr, Cdb_RobDepth, Div_ExeRdy,
    output DivQ_Full, Iss_Div, Iss_RobTag, Iss_RdPhyAddr, Iss_RdWrite,
           Iss_RsPhyAddr, Iss_RtPhyAddr
  );
endinterface

// File: rtl/div_issue_queue.sv
// Reservation queue for the non-pipelined divider: in-order allocate, oldest-ready issue,
// CDB wakeup snooping and branch-flush trimming of the young suffix.
module div_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             Clk,
  input logic             Resetb,
  div_issue_queue_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0] rob_tag;
    logic [5:0] rd;
    logic       rd_write;
    logic [5:0] rs;
    logic       rs_rdy;
    logic [5:0] rt;
    logic       rt_rdy;
  } entry_t;

  entry_t             r_q [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               r_full;

  entry_t             w_woke [DEPTH];
  entry_t             w_q_n  [DEPTH];
  entry_t             w_new;
  logic [CNT_W-1:0]   w_count_n;
  logic [CNT_W-1:0]   w_kept;
  logic [CNT_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_sel;
  logic               w_found;
  logic               w_iss;
  logic               w_disp;
  logic               w_hit;

  // Oldest entry whose operands were ready at the start of the cycle
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < r_count) && r_q[i].rs_rdy && r_q[i].rt_rdy) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end

  assign w_iss  = w_found & bus.Div_ExeRdy & ~bus.Cdb_Flush;
  assign w_disp = bus.Dis_DivWrite & ~r_full & ~bus.Cdb_Flush;
  assign w_hit  = bus.Cdb_Valid & bus.Cdb_RdWrite;

  assign bus.Iss_Div       = w_iss;
  assign bus.Iss_RobTag    = r_q[w_sel].rob_tag;
  assign bus.Iss_RdPhyAddr = r_q[w_sel].rd;
  assign bus.Iss_RdWrite   = r_q[w_sel].rd_write;
  assign bus.Iss_RsPhyAddr = r_q[w_sel].rs;
  assign bus.Iss_RtPhyAddr = r_q[w_sel].rt;
  assign bus.DivQ_Full     = r_full;

  // Wakeup of stored operands, incoming entry with same-cycle CDB bypass, and flush survivors
  always_comb begin
    w_new.rob_tag  = bus.Dis_RobTag;
    w_new.rd       = bus.Dis_RdPhyAddr;
    w_new.rd_write = bus.Dis_RdWrite;
    w_new.rs       = bus.Dis_RsPhyAddr;
    w_new.rs_rdy   = bus.Dis_RsReady | (w_hit && (bus.Dis_RsPhyAddr == bus.Cdb_RdPhyAddr));
    w_new.rt       = bus.Dis_RtPhyAddr;
    w_new.rt_rdy   = bus.Dis_RtReady | (w_hit && (bus.Dis_RtPhyAddr == bus.Cdb_RdPhyAddr));
    w_kept         = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_woke[i] = r_q[i];
      if (w_hit && (r_q[i].rs == bus.Cdb_RdPhyAddr)) w_woke[i].rs_rdy = 1'b1;
      if (w_hit && (r_q[i].rt == bus.Cdb_RdPhyAddr)) w_woke[i].rt_rdy = 1'b1;
      if ((CNT_W'(i) < r_count) &&
          (5'(r_q[i].rob_tag - bus.Rob_TopPtr) < bus.Cdb_RobDepth))
        w_kept = w_kept + CNT_W'(1);
    end
  end

  // Compaction on issue, then append of the dispatched entry
  always_comb begin
    w_q_n     = w_woke;
    w_base    = r_count - CNT_W'(w_iss);
    w_count_n = r_count;
    if (bus.Cdb_Flush) begin
      w_count_n = w_kept;
    end else begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (w_iss && (IDX_W'(i) >= w_sel)) w_q_n[i] = w_woke[i+1];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_disp && (CNT_W'(i) == w_base)) w_q_n[i] = w_new;
      end
      w_count_n = w_base + CNT_W'(w_disp);
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
    end else begin
      r_q     <= w_q_n;
      r_count <= w_count_n;
      r_full  <= (w_count_n == CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed scenarios then random traffic, checked by a
// queue-based reference model feeding a per-cycle scoreboard.
module tb_div_issue_queue;
  localparam int unsigned DEPTH = 4;

  logic Clk = 1'b0;
  logic Resetb = 1'b0;
  always #5 Clk = ~Clk;

  div_issue_queue_if bif ();

  div_issue_queue #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .Clk   (Clk),
    .Resetb(Resetb),
    .bus   (bif.slave)
  );

  typedef struct {
    logic [4:0] tag;
    logic [5:0] rd;
    logic       rdw;
    logic [5:0] rs;
    logic       rsr;
    logic [5:0] rt;
    logic       rtr;
  } ment_t;

  typedef struct {
    logic       iss;
    logic       full;
    logic [4:0] tag;
    logic [5:0] rd;
    logic       rdw;
    logic [5:0] rs;
    logic [5:0] rt;
  } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  bit    m_full;
  bit    m_acc;
  int    vectors;
  int    miscompares;

  logic       rstb;
  logic       d_wr, d_rdw, d_rsr, d_rtr;
  logic [4:0] d_tag;
  logic [5:0] d_rd, d_rs, d_rt;
  logic       c_v, c_rw, c_fl, exe;
  logic [5:0] c_addr;
  logic [4:0] top, depth;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    rstb = 1'b1; d_wr = 1'b0; d_tag = '0; d_rd = '0; d_rdw = 1'b1;
    d_rs = '0; d_rsr = 1'b1; d_rt = '0; d_rtr = 1'b1;
    c_v = 1'b0; c_rw = 1'b0; c_addr = '0; c_fl = 1'b0; top = '0; depth = '0;
    exe = 1'b1;
  endtask

  task automatic apply();
    Resetb = rstb;
    bif.Dis_DivWrite = d_wr;  bif.Dis_RobTag = d_tag;   bif.Dis_RdPhyAddr = d_rd;
    bif.Dis_RdWrite = d_rdw;  bif.Dis_RsPhyAddr = d_rs; bif.Dis_RsReady = d_rsr;
    bif.Dis_RtPhyAddr = d_rt; bif.Dis_RtReady = d_rtr;  bif.Cdb_Valid = c_v;
    bif.Cdb_RdWrite = c_rw;   bif.Cdb_RdPhyAddr = c_addr; bif.Cdb_Flush = c_fl;
    bif.Rob_TopPtr = top;     bif.Cdb_RobDepth = depth; bif.Div_ExeRdy = exe;
  endtask

  // Reference: program-ordered list; predict this cycle's outputs, then advance one edge
  function automatic void model();
    exp_t  e;
    ment_t n;
    ment_t keep[$];
    int    sel = -1;
    bit    hit;
    e = '{default: '0};
    m_acc = 1'b0;
    if (!rstb) begin
      mq.delete();
      m_full = 1'b0;
      sb.push_back(e);
      return;
    end
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].rsr && mq[i].rtr) sel = i;
    e.full = m_full;
    e.iss  = (sel >= 0) && exe && !c_fl;
    if (e.iss) begin
      e.tag = mq[sel].tag; e.rd = mq[sel].rd; e.rdw = mq[sel].rdw;
      e.rs = mq[sel].rs;   e.rt = mq[sel].rt;
    end
    sb.push_back(e);
    hit = c_v && c_rw;
    for (int i = 0; i < mq.size(); i++) begin
      if (hit && mq[i].rs == c_addr) mq[i].rsr = 1'b1;
      if (hit && mq[i].rt == c_addr) mq[i].rtr = 1'b1;
    end
    if (c_fl) begin
      foreach (mq[i]) if (5'(mq[i].tag - top) < depth) keep.push_back(mq[i]);
      mq = keep;
    end else begin
      if (e.iss) mq.delete(sel);
      if (d_wr && !m_full) begin
        n.tag = d_tag; n.rd = d_rd; n.rdw = d_rdw; n.rs = d_rs; n.rt = d_rt;
        n.rsr = d_rsr || (hit && d_rs == c_addr);
        n.rtr = d_rtr || (hit && d_rt == c_addr);
        mq.push_back(n);
        m_acc = 1'b1;
      end
    end
    m_full = (mq.size() == DEPTH);
  endfunction

  task automatic step();
    @(negedge Clk);
    apply();
    model();
  endtask

  task automatic disp(input logic [4:0] tag, input logic [5:0] rs, input logic rsr,
                      input logic [5:0] rt, input logic rtr);
    d_wr = 1'b1; d_tag = tag; d_rd = 6'(tag) + 6'd32; d_rs = rs; d_rsr = rsr;
    d_rt = rt; d_rtr = rtr;
  endtask

  // Monitor: compares DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("iss_div", 32'(bif.Iss_Div), 32'(e.iss));
        chk("divq_full", 32'(bif.DivQ_Full), 32'(e.full));
        if (e.iss && bif.Iss_Div) begin
          chk("iss_robtag", 32'(bif.Iss_RobTag), 32'(e.tag));
          chk("iss_rd", 32'(bif.Iss_RdPhyAddr), 32'(e.rd));
          chk("iss_rdwrite", 32'(bif.Iss_RdWrite), 32'(e.rdw));
          chk("iss_rs", 32'(bif.Iss_RsPhyAddr), 32'(e.rs));
          chk("iss_rt", 32'(bif.Iss_RtPhyAddr), 32'(e.rt));
        end
      end
    end
  end

  initial begin
    logic [4:0] nxt;
    idle(); rstb = 1'b0; apply();
    step(); step();

    // Reset while three entries are waiting, then a fresh dispatch
    for (int i = 0; i < 3; i++) begin idle(); disp(5'(i + 1), 6'd9, 1'b0, 6'd1, 1'b1); step(); end
    idle(); rstb = 1'b0; step();
    idle(); step();
    idle(); disp(5'd7, 6'd2, 1'b1, 6'd3, 1'b1); step();
    idle(); step(); step();

    // Single ready instruction goes straight through
    idle(); disp(5'd5, 6'd1, 1'b1, 6'd2, 1'b1); step();
    idle(); step(); step();

    // Younger ready entry bypasses older blocked one; wakeup releases the older
    idle(); disp(5'd10, 6'd12, 1'b0, 6'd3, 1'b1); step();
    idle(); disp(5'd11, 6'd4, 1'b1, 6'd5, 1'b1); step();
    idle(); step();
    idle(); c_v = 1'b1; c_rw = 1'b1; c_addr = 6'd12; step();
    idle(); step(); step();

    // Fill, free one slot, then hammer dispatch
    for (int i = 0; i < 4; i++) begin idle(); exe = 1'b0; disp(5'(8 + i), 6'd1, 1'b1, 6'd1, 1'b1); step(); end
    idle(); exe = 1'b0; step();
    idle(); step();
    for (int i = 0; i < 4; i++) begin idle(); exe = 1'b0; disp(5'(12 + i), 6'd1, 1'b1, 6'd1, 1'b1); step(); end
    for (int i = 0; i < 6; i++) begin idle(); step(); end

    // Flush across tag wrap: top=30, depth=3 keeps only tag 31
    idle(); disp(5'd31, 6'd40, 1'b0, 6'd1, 1'b1); step();
    idle(); disp(5'd1, 6'd41, 1'b0, 6'd1, 1'b1); step();
    idle(); disp(5'd3, 6'd42, 1'b0, 6'd1, 1'b1); step();
    idle(); c_fl = 1'b1; top = 5'd30; depth = 5'd3; disp(5'd4, 6'd1, 1'b1, 6'd1, 1'b1); step();
    idle(); c_v = 1'b1; c_rw = 1'b1; c_addr = 6'd41; step();
    idle(); c_v = 1'b1; c_rw = 1'b1; c_addr = 6'd40; step();
    idle(); step(); step();

    // Dispatch-cycle CDB bypass on Rt
    idle(); disp(5'd6, 6'd7, 1'b1, 6'd20, 1'b0); c_v = 1'b1; c_rw = 1'b1; c_addr = 6'd20; step();
    idle(); step(); step();

    // Random traffic
    idle(); rstb = 1'b0; step();
    nxt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rstb   = ($urandom_range(0, 499) != 0);
      exe    = ($urandom_range(0, 9) < 6);
      c_v    = ($urandom_range(0, 9) < 4);
      c_rw   = ($urandom_range(0, 9) < 8);
      c_addr = 6'($urandom_range(0, 7));
      c_fl   = ($urandom_range(0, 19) == 0);
      depth  = 5'($urandom_range(0, 6));
      d_wr   = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && 5'(nxt - mq[0].tag) >= 5'd24) d_wr = 1'b0;
      top    = (mq.size() > 0) ? 5'(mq[0].tag - 5'($urandom_range(0, 3)))
                               : 5'(nxt - 5'($urandom_range(0, 3)));
      d_tag = nxt; d_rd = 6'($urandom); d_rdw = 1'($urandom);
      d_rs = 6'($urandom_range(0, 7)); d_rsr = 1'($urandom);
      d_rt = 6'($urandom_range(0, 7)); d_rtr = 1'($urandom);
      step();
      if (m_acc) nxt = nxt + 5'd1;
    end
    for (int i = 0; i < 3; i++) begin idle(); c_v = 1'b0; step(); end
    @(negedge Clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- In-order-allocated, out-of-order-issue reservation queue for the single non-pipelined 16-bit divider.
- Accepts divide instructions from dispatch and tracks operand readiness by snooping CDB broadcasts.
- Issues the oldest ready entry whenever the divider reports ready, and discards wrong-path entries on a CDB branch flush.
- Sits between dispatch and the divider; its issue outputs also drive the physical register file read ports.

Parameters:
DEPTH, 4, number of queue entries (power of 2, 2..8)
CNT_W, 3, width of occupancy counter (must hold 0..DEPTH)

Ports:
Clk  in  1  clock, rising edge
Resetb  in  1  asynchronous active-low reset
Dis_DivWrite  in  1  dispatch writes one div instruction this cycle
Dis_RobTag  in  5  ROB tag of dispatched instruction
Dis_RdPhyAddr  in  6  destination physical register
Dis_RdWrite  in  1  instruction writes a register
Dis_RsPhyAddr  in  6  source Rs physical register
Dis_RsReady  in  1  Rs value already available at dispatch
Dis_RtPhyAddr  in  6  source Rt physical register
Dis_RtReady  in  1  Rt value already available at dispatch
Cdb_Valid  in  1  CDB carries a result this cycle
Cdb_RdWrite  in  1  CDB result writes a register
Cdb_RdPhyAddr  in  6  CDB destination physical register (wakeup tag)
Cdb_Flush  in  1  branch mispredict flush
Rob_TopPtr  in  5  ROB head pointer
Cdb_RobDepth  in  5  depth of mispredicted branch relative to ROB head
Div_ExeRdy  in  1  divider can accept an instruction this cycle
DivQ_Full  out  1  queue full; dispatch must not assert Dis_DivWrite
Iss_Div  out  1  issue strobe to divider
Iss_RobTag  out  5  tag of issued entry
Iss_RdPhyAddr  out  6  destination of issued entry
Iss_RdWrite  out  1  RdWrite of issued entry
Iss_RsPhyAddr  out  6  register-file read address Rs
Iss_RtPhyAddr  out  6  register-file read address Rt

Behaviour:
- Storage: DEPTH entries, index 0 = oldest. Valid entries are contiguous 0..count-1 and kept in program order. Each entry holds RobTag, RdPhyAddr, RdWrite, RsPhyAddr, RsReady, RtPhyAddr, RtReady.
- Reset (async): count=0, all ready bits 0, DivQ_Full=0, Iss_Div=0. Other Iss_* outputs are don't-care.
- Wakeup: a wakeup hit occurs when Cdb_Valid & Cdb_RdWrite and Cdb_RdPhyAddr equals a stored Rs/Rt address. A hit sets that ready bit at the next edge.
- Dispatch bypass: a dispatched operand whose address hits the CDB in the same cycle is written with its ready bit set.
- Selection (combinational): lowest index with RsReady & RtReady. Ready bits set by wakeup this cycle do not count until the next cycle, so wakeup-to-issue latency is 1 cycle minimum.
- Iss_Div = found & Div_ExeRdy & !Cdb_Flush. Iss_* fields always reflect the selected entry (entry 0 if none is ready).
- Issue removal: on Iss_Div, entries above the selected index shift down by one and count decrements.
- Dispatch write: a simultaneous dispatch lands at index count-1 after the shift; otherwise at index count.
- Dispatch: accepted when Dis_DivWrite & !DivQ_Full & !Cdb_Flush. It is ignored during flush because dispatch is being redirected. Dispatch while full is a protocol error and is ignored.
- Flush:
  - An entry is kept iff ((RobTag - Rob_TopPtr) mod 32) < Cdb_RobDepth.
  - Because entries are in program order, the flushed entries form a suffix: the new count is the number of kept entries.
  - No issue occurs in a flush cycle.
  - Ready bits of survivors are still updated by wakeup.
- DivQ_Full: registered, equals (next count == DEPTH).
- Wrap-around: ROB tag subtraction is modulo 32, so ages compare correctly across tag wrap.
- Simultaneous dispatch + issue when full is allowed only if DivQ_Full was low. Issue frees a slot for the next cycle, not the same cycle.

Test Plan:
- Reset mid-operation with count=3 -> next cycle DivQ_Full=0, Iss_Div=0; a new dispatch lands at index 0.
- Dispatch tag 5 with both operands ready, Div_ExeRdy=1 -> Iss_Div=1 one cycle later, Iss_RobTag=5; queue returns to empty.
- Dispatch A (Rs=12 not ready) then B (ready) -> B issues first. CDB broadcast of phys 12 -> A issues on the following cycle.
- Fill 4 entries with Div_ExeRdy=0 -> DivQ_Full=1. Issue one -> DivQ_Full=0 the next cycle; 4 subsequent dispatches are not all accepted.
- Rob_TopPtr=30, entries with tags 31,1,3, Cdb_RobDepth=3 -> tags 1 and 3 flushed, count=1 (tag 31 kept); Iss_Div=0 during the flush cycle.
- Dispatch with Rt=20 in the same cycle as a CDB broadcast of 20, Rs ready -> entry issues next cycle with no further wakeup.
